// File: rtl/clk_lock_sequencer.sv
// DCM/PLL lock sequencer: reset pulse, filtered lock wait with timeout/retry, staged domain reset release.
// Lock loss reaches dom_rst_o in 3 cycles; no backpressure; `CLK_SEQ_LOSS_RECOVERY_EN` retries on lock loss instead of faulting.

module clk_lock_filter #(
  parameter int LOCK_FILTER = 8
) (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  input  logic locked_i,
  output logic lock_filt
);

  logic [1:0]  sync_q;
  logic [15:0] cnt_q;
  logic        filt_q;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      sync_q <= 2'b00;
      cnt_q  <= 16'd0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], locked_i};
      if (!sync_q[1]) begin
        cnt_q  <= 16'd0;
        filt_q <= 1'b0;
      end else if (!filt_q) begin
        if (cnt_q == 16'(LOCK_FILTER - 1)) filt_q <= 1'b1;
        else                               cnt_q  <= cnt_q + 16'd1;
      end
    end
  end

  // Rising edge is filtered; falling edge bypasses the filter register.
  assign lock_filt = sync_q[1] & filt_q;

endmodule

module clk_lock_sequencer #(
  parameter int N_DOMAINS      = 3,
  parameter int DCM_RST_CYCLES = 4,
  parameter int LOCK_FILTER    = 8,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int STAGE_DELAY    = 16,
  parameter int MAX_RETRY      = 15
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic                 dcm_locked_i,
  input  logic                 pll_locked_i,
  output logic                 dcm_rst_o,
  output logic                 pll_rst_o,
  output logic [N_DOMAINS-1:0] dom_rst_o,
  output logic                 ready_o,
  output logic                 fault_o,
  output logic [7:0]           retry_cnt_o
);

  typedef enum logic [2:0] {
    S_DCM_RST,
    S_WAIT_DCM,
    S_WAIT_PLL,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_t;

  localparam logic [15:0] RST_LAST    = 16'(DCM_RST_CYCLES - 1);
  localparam logic [15:0] TMO_LAST    = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] REL_LAST    = 16'(N_DOMAINS * STAGE_DELAY);
  localparam logic [8:0]  RETRY_LIMIT = (MAX_RETRY > 255) ? 9'd256 : 9'(MAX_RETRY);

  state_t      state_q;
  logic [15:0] timer_q;
  logic        dcm_lock;
  logic        pll_lock;
  logic        tmo;
  logic        do_retry;
  logic        do_fault;
  logic        budget_out;
  logic        go_fault;
  logic        go_restart;

  clk_lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_dcm_filt (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .locked_i  (dcm_locked_i),
    .lock_filt (dcm_lock)
  );

  clk_lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_pll_filt (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .locked_i  (pll_locked_i),
    .lock_filt (pll_lock)
  );

  assign tmo = (timer_q == TMO_LAST);

  // An accepted lock masks a coincident timeout.
  always_comb begin
    do_retry = 1'b0;
    do_fault = 1'b0;
    unique case (state_q)
      S_WAIT_DCM: do_retry = !dcm_lock && tmo;
      S_WAIT_PLL: do_retry = !dcm_lock || (!pll_lock && tmo);
      S_RELEASE, S_RUN: begin
`ifdef CLK_SEQ_LOSS_RECOVERY_EN
        do_retry = !(dcm_lock && pll_lock);
`else
        do_fault = !(dcm_lock && pll_lock);
`endif
      end
      default: ;
    endcase
  end

  assign budget_out = ({1'b0, retry_cnt_o} >= RETRY_LIMIT);
  assign go_fault   = do_fault || (do_retry && budget_out);
  assign go_restart = do_retry && !budget_out;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q     <= S_DCM_RST;
      timer_q     <= 16'd0;
      dcm_rst_o   <= 1'b1;
      pll_rst_o   <= 1'b1;
      dom_rst_o   <= '1;
      ready_o     <= 1'b0;
      fault_o     <= 1'b0;
      retry_cnt_o <= 8'd0;
    end else if (go_fault) begin
      state_q   <= S_FAULT;
      timer_q   <= 16'd0;
      dcm_rst_o <= 1'b1;
      pll_rst_o <= 1'b1;
      dom_rst_o <= '1;
      ready_o   <= 1'b0;
      fault_o   <= 1'b1;
    end else if (go_restart) begin
      state_q   <= S_DCM_RST;
      timer_q   <= 16'd0;
      dcm_rst_o <= 1'b1;
      pll_rst_o <= 1'b1;
      dom_rst_o <= '1;
      ready_o   <= 1'b0;
      if (retry_cnt_o != 8'hFF) retry_cnt_o <= retry_cnt_o + 8'd1;
    end else begin
      unique case (state_q)
        S_DCM_RST: begin
          if (timer_q == RST_LAST) begin
            state_q   <= S_WAIT_DCM;
            timer_q   <= 16'd0;
            dcm_rst_o <= 1'b0;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_WAIT_DCM: begin
          if (dcm_lock) begin
            state_q   <= S_WAIT_PLL;
            timer_q   <= 16'd0;
            pll_rst_o <= 1'b0;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_WAIT_PLL: begin
          if (pll_lock) begin
            state_q <= S_RELEASE;
            timer_q <= 16'd0;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_RELEASE: begin
          // Domain i leaves reset on the (i+1)*STAGE_DELAY-th edge after entry.
          for (int i = 0; i < N_DOMAINS; i++) begin
            if (timer_q == 16'((i + 1) * STAGE_DELAY - 1)) dom_rst_o[i] <= 1'b0;
          end
          if (timer_q == REL_LAST) begin
            state_q <= S_RUN;
            timer_q <= 16'd0;
            ready_o <= 1'b1;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_RUN:   ;
        S_FAULT: ;
        default: begin
          state_q   <= S_FAULT;
          timer_q   <= 16'd0;
          dcm_rst_o <= 1'b1;
          pll_rst_o <= 1'b1;
          dom_rst_o <= '1;
          ready_o   <= 1'b0;
          fault_o   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_lock_sequencer.sv
// Directed bench for clk_lock_sequencer; cycle numbers count edges after the last reset edge.
// Expected cycle positions below are hand-derived for the bench parameter set.

module tb_clk_lock_sequencer;

  logic       sys_clk_i = 1'b0;
  logic       sys_rst_i = 1'b1;
  logic       dcm_locked_i = 1'b0;
  logic       pll_locked_i = 1'b0;
  logic       dcm_rst_o;
  logic       pll_rst_o;
  logic [2:0] dom_rst_o;
  logic       ready_o;
  logic       fault_o;
  logic [7:0] retry_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 sys_clk_i = ~sys_clk_i;

  clk_lock_sequencer #(
    .N_DOMAINS      (3),
    .DCM_RST_CYCLES (4),
    .LOCK_FILTER    (8),
    .LOCK_TIMEOUT   (1000),
    .STAGE_DELAY    (16),
    .MAX_RETRY      (3)
  ) dut (
    .sys_clk_i    (sys_clk_i),
    .sys_rst_i    (sys_rst_i),
    .dcm_locked_i (dcm_locked_i),
    .pll_locked_i (pll_locked_i),
    .dcm_rst_o    (dcm_rst_o),
    .pll_rst_o    (pll_rst_o),
    .dom_rst_o    (dom_rst_o),
    .ready_o      (ready_o),
    .fault_o      (fault_o),
    .retry_cnt_o  (retry_cnt_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk_i);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic apply_reset;
    sys_rst_i = 1'b1;
    repeat (3) tick();
    sys_rst_i = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int t_pll;
    int t_rdy;
    int t_dom [3];
    int pll_low;

    // Nominal bring-up: locks rise 20 cycles after reset release
    dcm_locked_i = 1'b0;
    pll_locked_i = 1'b0;
    apply_reset();
    check_val("rst_dcm_rst", dcm_rst_o, 1);
    check_val("rst_pll_rst", pll_rst_o, 1);
    check_val("rst_dom_rst", dom_rst_o, 7);
    check_val("rst_ready", ready_o, 0);
    check_val("rst_fault", fault_o, 0);
    check_val("rst_retry", retry_cnt_o, 0);
    hi = 0;
    while (cyc < 20) begin
      if (dcm_rst_o) hi++;
      tick();
    end
    dcm_locked_i = 1'b1;
    pll_locked_i = 1'b1;
    check_val("nom_dcm_rst_len", hi, 4);
    t_pll = -1;
    t_rdy = -1;
    for (int i = 0; i < 3; i++) t_dom[i] = -1;
    while (cyc < 200 && !ready_o) begin
      tick();
      if (t_pll < 0 && !pll_rst_o) t_pll = cyc;
      for (int i = 0; i < 3; i++) if (t_dom[i] < 0 && !dom_rst_o[i]) t_dom[i] = cyc;
    end
    if (ready_o) t_rdy = cyc;
    check_val("nom_pll_release_cyc", t_pll, 31);
    check_val("nom_dom0_after_rel", t_dom[0] - (t_pll + 1), 16);
    check_val("nom_dom1_after_rel", t_dom[1] - (t_pll + 1), 32);
    check_val("nom_dom2_after_rel", t_dom[2] - (t_pll + 1), 48);
    check_val("nom_ready_cyc", t_rdy, 81);
    check_val("nom_ready_resets", {dcm_rst_o, pll_rst_o, dom_rst_o}, 0);
    check_val("nom_retry", retry_cnt_o, 0);

    // Loss of PLL lock in RUN: one-cycle low pulse on the pin
    run_to(90);
    pll_locked_i = 1'b0;
    tick();
    pll_locked_i = 1'b1;
    run_to(92);
    check_val("loss_ready_before", ready_o, 1);
    check_val("loss_dom_before", dom_rst_o, 0);
    tick();
    check_val("loss_dom_rst", dom_rst_o, 7);
    check_val("loss_ready", ready_o, 0);
`ifdef CLK_SEQ_LOSS_RECOVERY_EN
    check_val("loss_retry", retry_cnt_o, 1);
    check_val("loss_fault", fault_o, 0);
    while (cyc < 400 && !ready_o) tick();
    check_val("loss_reready", ready_o, 1);
    check_val("loss_reready_retry", retry_cnt_o, 1);
`else
    check_val("loss_fault", fault_o, 1);
    check_val("loss_retry", retry_cnt_o, 0);
    check_val("loss_dcm_rst", dcm_rst_o, 1);
`endif

    // DCM never locks: re-pulse every 1004 cycles, fault on the 4th timeout
    dcm_locked_i = 1'b0;
    pll_locked_i = 1'b0;
    apply_reset();
    run_to(3);
    check_val("nolock_dcm_rst_c3", dcm_rst_o, 1);
    run_to(4);
    check_val("nolock_dcm_rst_c4", dcm_rst_o, 0);
    check_val("nolock_pll_rst_c4", pll_rst_o, 1);
    run_to(1003);
    check_val("nolock_dcm_rst_c1003", dcm_rst_o, 0);
    check_val("nolock_retry_c1003", retry_cnt_o, 0);
    run_to(1004);
    check_val("nolock_dcm_rst_c1004", dcm_rst_o, 1);
    check_val("nolock_retry_c1004", retry_cnt_o, 1);
    run_to(2007);
    check_val("nolock_dcm_rst_c2007", dcm_rst_o, 0);
    run_to(2008);
    check_val("nolock_dcm_rst_c2008", dcm_rst_o, 1);
    check_val("nolock_retry_c2008", retry_cnt_o, 2);
    run_to(3012);
    check_val("nolock_retry_c3012", retry_cnt_o, 3);
    run_to(4015);
    check_val("nolock_fault_c4015", fault_o, 0);
    run_to(4016);
    check_val("nolock_fault_c4016", fault_o, 1);
    check_val("nolock_resets_c4016", {dcm_rst_o, pll_rst_o, dom_rst_o}, 31);
    check_val("nolock_ready_c4016", ready_o, 0);
    check_val("nolock_retry_c4016", retry_cnt_o, 3);
    run_to(4100);
    check_val("nolock_fault_sticky", fault_o, 1);
    sys_rst_i = 1'b1;
    tick();
    check_val("fault_clr_fault", fault_o, 0);
    check_val("fault_clr_retry", retry_cnt_o, 0);
    sys_rst_i = 1'b0;

    // Glitchy DCM lock: 5 high / 1 low never passes the filter
    pll_locked_i = 1'b1;
    apply_reset();
    pll_low = 0;
    while (cyc < 1004) begin
      dcm_locked_i = (cyc % 6) != 5;
      if (cyc >= 4 && !pll_rst_o) pll_low++;
      if (cyc == 1003) check_val("glitch_dcm_rst_c1003", dcm_rst_o, 0);
      tick();
    end
    check_val("glitch_pll_never_released", pll_low, 0);
    check_val("glitch_dcm_rst_c1004", dcm_rst_o, 1);
    check_val("glitch_retry_c1004", retry_cnt_o, 1);

    // Lock accepted on the same cycle the timeout would fire
    dcm_locked_i = 1'b0;
    pll_locked_i = 1'b1;
    apply_reset();
    run_to(993);
    dcm_locked_i = 1'b1;
    run_to(1003);
    check_val("simul_pll_rst_c1003", pll_rst_o, 1);
    run_to(1004);
    check_val("simul_pll_rst_c1004", pll_rst_o, 0);
    check_val("simul_dcm_rst_c1004", dcm_rst_o, 0);
    check_val("simul_retry_c1004", retry_cnt_o, 0);

    // Reset pulse mid-RELEASE with dom_rst_o = 3'b110
    dcm_locked_i = 1'b1;
    pll_locked_i = 1'b1;
    apply_reset();
    run_to(30);
    check_val("midrst_dom_before", dom_rst_o, 6);
    check_val("midrst_pll_before", pll_rst_o, 0);
    sys_rst_i = 1'b1;
    tick();
    check_val("midrst_dcm_rst", dcm_rst_o, 1);
    check_val("midrst_pll_rst", pll_rst_o, 1);
    check_val("midrst_dom_rst", dom_rst_o, 7);
    check_val("midrst_ready", ready_o, 0);
    check_val("midrst_fault_retry", {fault_o, retry_cnt_o}, 0);
    sys_rst_i = 1'b0;
    cyc = 0;
    run_to(3);
    check_val("midrst_restart_dcm_c3", dcm_rst_o, 1);
    run_to(4);
    check_val("midrst_restart_dcm_c4", dcm_rst_o, 0);
    while (cyc < 200 && !ready_o) tick();
    check_val("midrst_ready_again", ready_o, 1);
    check_val("midrst_ready_cyc", cyc, 61);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
